// File: rtl/sidetone_pkg.sv
// Shared types and constants for the sidetone NCO: key-envelope states,
// quadrant bit roles and the quarter-wave table generator.
package sidetone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_HOLD = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  // Bit 0 of the quadrant mirrors the table address, bit 1 negates the value.
  localparam int QUAD_MIRROR_BIT = 0;
  localparam int QUAD_NEGATE_BIT = 1;

  localparam real HALF_PI = 1.5707963267948966;

  // Half-step offset keeps the table symmetric, so mirroring never repeats an entry.
  function automatic int quarter_sine_entry(input int k, input int lut_aw, input int out_w);
    real amp;
    real ang;
    amp = real'((1 << (out_w - 1)) - 1);
    ang = HALF_PI * (real'(k) + 0.5) / real'(1 << lut_aw);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table with a one-clock registered read, sized for block RAM.
module quarter_sine_rom
  import sidetone_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 16
) (
  input  logic              clock,
  input  logic [LUT_AW-1:0] addr,
  output logic [OUT_W-2:0]  data
);

  logic [OUT_W-2:0] rom_table [2**LUT_AW];

  generate
    for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_rom
      assign rom_table[gi] = (OUT_W-1)'(quarter_sine_entry(gi, LUT_AW, OUT_W));
    end
  endgenerate

  always_ff @(posedge clock) begin
    data <= rom_table[addr];
  end

endmodule

// File: rtl/sidetone_nco.sv
// CW sidetone: phase-accumulator sine, raised-cosine key envelope and level gain,
// one output sample per sample_en strobe with a fixed 4-clock pipeline.
module sidetone_nco
  import sidetone_pkg::*;
#(
  parameter int OUT_W   = 16,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int ENV_W   = 20,
  parameter int LEVEL_W = 8
) (
  input  logic                      clock,
  input  logic                      rst_n,
  input  logic                      sample_en,
  input  logic [PHASE_W-1:0]        phase_inc,
  input  logic [ENV_W-1:0]          env_inc,
  input  logic [LEVEL_W-1:0]        level,
  input  logic                      key,
  output logic signed [OUT_W-1:0]   tone_out,
  output logic                      tone_valid,
  output logic                      busy
);

  localparam logic [ENV_W-1:0] ENV_MAX  = '1;
  localparam logic [OUT_W-2:0] ENV_FULL = '1;
  localparam int SQ_W   = 2*OUT_W - 2;
  localparam int PROD_W = 2*OUT_W;
  localparam int GAIN_W = OUT_W + LEVEL_W + 1;

  state_t             state_reg, state_next;
  logic [PHASE_W-1:0] phase_acc_reg, phase_acc_next;
  logic [ENV_W-1:0]   env_acc_reg, env_acc_next;
  logic [ENV_W:0]     env_sum;

  always_comb begin
    state_next     = state_reg;
    phase_acc_next = phase_acc_reg + phase_inc;
    env_acc_next   = env_acc_reg;
    env_sum        = {1'b0, env_acc_reg} + {1'b0, env_inc};
    case (state_reg)
      ST_IDLE: begin
        phase_acc_next = '0;
        env_acc_next   = '0;
        if (key) state_next = ST_RISE;
      end
      ST_RISE: begin
        if (!key) begin
          state_next = ST_FALL;
        end else if (env_inc == '0 || env_sum >= {1'b0, ENV_MAX}) begin
          env_acc_next = ENV_MAX;
          state_next   = ST_HOLD;
        end else begin
          env_acc_next = env_sum[ENV_W-1:0];
        end
      end
      ST_HOLD: begin
        env_acc_next = ENV_MAX;
        if (!key) state_next = ST_FALL;
      end
      ST_FALL: begin
        if (key) begin
          state_next = ST_RISE;
        end else if (env_inc == '0 || env_acc_reg <= env_inc) begin
          env_acc_next   = '0;
          phase_acc_next = '0;
          state_next     = ST_IDLE;
        end else begin
          env_acc_next = env_acc_reg - env_inc;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      phase_acc_reg <= '0;
      env_acc_reg   <= '0;
    end else if (sample_en) begin
      state_reg     <= state_next;
      phase_acc_reg <= phase_acc_next;
      env_acc_reg   <= env_acc_next;
    end
  end

  assign busy = (state_reg != ST_IDLE);

  // ROM addresses come from the pre-update accumulators, so each sample sees the old state.
  logic [1:0]        quadrant;
  logic [LUT_AW-1:0] tone_raw, tone_addr, env_addr;
  logic [OUT_W-2:0]  tone_mag, env_mag;

  assign quadrant  = phase_acc_reg[PHASE_W-1 -: 2];
  assign tone_raw  = LUT_AW'(phase_acc_reg >> (PHASE_W - 2 - LUT_AW));
  assign tone_addr = quadrant[QUAD_MIRROR_BIT] ? ~tone_raw : tone_raw;
  assign env_addr  = LUT_AW'(env_acc_reg >> (ENV_W - LUT_AW));

  quarter_sine_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_tone_rom (
    .clock (clock),
    .addr  (tone_addr),
    .data  (tone_mag)
  );

  quarter_sine_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_env_rom (
    .clock (clock),
    .addr  (env_addr),
    .data  (env_mag)
  );

  logic                      s1_valid, s2_valid, s3_valid;
  logic                      s1_negate;
  state_t                    s1_state;
  logic [LEVEL_W-1:0]        s1_level, s2_level, s3_level;
  logic signed [OUT_W-1:0]   s2_sine, s3_mix;
  logic [OUT_W-2:0]          s2_env;

  logic signed [OUT_W-1:0]   sine_mag_s, sine_next, mix_next, tone_next;
  logic [SQ_W-1:0]           env_sq;
  logic [OUT_W-2:0]          env_shaped;
  logic signed [PROD_W-1:0]  mix_full;
  logic signed [GAIN_W-1:0]  gain_full;

  assign sine_mag_s = $signed({1'b0, tone_mag});
  assign sine_next  = s1_negate ? -sine_mag_s : sine_mag_s;
  assign env_sq     = SQ_W'(env_mag) * SQ_W'(env_mag);

  // Squaring the sine table turns a linear ramp into a raised-cosine edge.
  always_comb begin
    env_shaped = (OUT_W-1)'(env_sq >> (OUT_W - 1));
    case (s1_state)
      ST_IDLE: env_shaped = '0;
      ST_HOLD: env_shaped = ENV_FULL;
      default: ;
    endcase
  end

  assign mix_full  = PROD_W'(s2_sine) * PROD_W'($signed({1'b0, s2_env}));
  assign mix_next  = OUT_W'(mix_full >>> (OUT_W - 1));
  assign gain_full = GAIN_W'(s3_mix) * GAIN_W'($signed({1'b0, s3_level}));
  assign tone_next = OUT_W'(gain_full >>> LEVEL_W);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      tone_valid <= 1'b0;
      tone_out   <= '0;
    end else begin
      s1_valid   <= sample_en;
      s2_valid   <= s1_valid;
      s3_valid   <= s2_valid;
      tone_valid <= s3_valid;
      if (s3_valid) tone_out <= tone_next;
    end
  end

  always_ff @(posedge clock) begin
    s1_negate <= quadrant[QUAD_NEGATE_BIT];
    s1_state  <= state_reg;
    s1_level  <= level;
    s2_sine   <= sine_next;
    s2_env    <= env_shaped;
    s2_level  <= s1_level;
    s3_mix    <= mix_next;
    s3_level  <= s2_level;
  end

endmodule
